// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
// Shares the single-port 64x32 data RAM between requester 0 (core LSU) and
// requester 1 (debug/DMA loader). Arbitration is round-robin and decided
// combinationally every cycle. The RAM has a 1-cycle registered read, so each
// grant produces a one-cycle rvalid pulse on the following cycle. An access
// whose byte address is not word aligned is still granted. It never writes
// the RAM and responds with err=1.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   pN_req/we/addr/wdata    requester N access (held until granted)
//   pN_gnt                  access accepted this cycle (combinational)
//   pN_rvalid/rdata/err     response, cycle after grant
//   ram_we/addr/din         to RAM wea/addra/dina
//   ram_dout                from RAM douta
//   contention_cnt          saturating count of cycles with both req high
module data_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RAM_AW = 6,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [CNT_W-1:0]  contention_cnt
);

  logic              rr_ptr;   // requester favoured when both request
  logic              sel_q;    // last winner; keeps RAM address/data stable when idle
  logic              any_gnt;
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              aligned;
  logic [1:0]        rsp_v;    // response due this cycle, one bit per requester
  logic              rsp_err;
  logic              rsp_rd;   // response carries RAM read data

  always_comb begin
    p0_gnt    = p0_req & (~p1_req | ~rr_ptr);
    p1_gnt    = p1_req & (~p0_req |  rr_ptr);
    any_gnt   = p0_gnt | p1_gnt;
    sel       = any_gnt ? p1_gnt : sel_q;
    sel_we    = sel ? p1_we    : p0_we;
    sel_addr  = sel ? p1_addr  : p0_addr;
    sel_wdata = sel ? p1_wdata : p0_wdata;
    aligned   = (sel_addr[1:0] == 2'b00);
    // rst_n in the write enable keeps a grant in the reset cycle from writing
    ram_we    = any_gnt & sel_we & aligned & rst_n;
    ram_addr  = sel_addr[RAM_AW+1:2];
    ram_din   = sel_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr         <= 1'b0;
      sel_q          <= 1'b0;
      rsp_v          <= 2'b00;
      rsp_err        <= 1'b0;
      rsp_rd         <= 1'b0;
      contention_cnt <= '0;
    end else begin
      rsp_v <= {p1_gnt, p0_gnt};
      if (any_gnt) begin
        rr_ptr  <= ~p1_gnt;
        sel_q   <= p1_gnt;
        rsp_err <= ~aligned;
        rsp_rd  <= ~sel_we & aligned;
      end
      if (p0_req && p1_req && (contention_cnt != {CNT_W{1'b1}}))
        contention_cnt <= contention_cnt + 1'b1;
    end
  end

  // Responses are masked while reset is held so nothing leaks out of a reset cycle
  always_comb begin
    p0_rvalid = rsp_v[0] & rst_n;
    p1_rvalid = rsp_v[1] & rst_n;
    p0_err    = p0_rvalid & rsp_err;
    p1_err    = p1_rvalid & rsp_err;
    p0_rdata  = (p0_rvalid & rsp_rd) ? ram_dout : '0;
    p1_rdata  = (p1_rvalid & rsp_rd) ? ram_dout : '0;
  end

endmodule
